ans_table_arbiter: RTL and testbench

ANS_TABLE_ARBITER -- requirements
Module: ans_table_arbiter

---
 rtl/ans_table_arbiter_pkg.sv | 17 +
 rtl/ans_table_arbiter_rr.sv | 14 +
 rtl/ans_table_arbiter.sv | 112 +++++++++++
 tb/tb_ans_table_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ans_table_arbiter_pkg.sv
// Shared ANS table definitions: symbol/count widths and table read request types,
// used by the encoder, the decoder and the table arbiter.
package ans_table_arbiter_pkg;

  localparam int SYM_WIDTH = 8;
  localparam int CNT_WIDTH = 12;
  localparam int SYM_COUNT = 1 << SYM_WIDTH;
  localparam int QW        = CNT_WIDTH + SYM_WIDTH;

  typedef enum logic [1:0] {
    READ_TYPE_NONE = 2'd0,
    READ_TYPE_PMF  = 2'd1,
    READ_TYPE_CMF  = 2'd2,
    READ_TYPE_ICMF = 2'd3
  } read_type_e;

endpackage

// File: rtl/ans_table_arbiter_rr.sv
// Two-request round-robin pick: a lone request wins outright; on contention the
// pointer chooses (0 -> requester 0, 1 -> requester 1). Output is one-hot or zero.
module ans_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = ptr_i ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/ans_table_arbiter.sv
// Arbitrates the shared frequency table between encoder (r0) and decoder (r1);
// results are forwarded only while the owner still asks exactly what was latched.
module ans_table_arbiter
  import ans_table_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [1:0]    r0_read_type,
  input  logic [QW-1:0] r0_read_query,
  output logic [QW-1:0] r0_read_result,
  output logic          r0_read_rdy,
  input  logic [1:0]    r1_read_type,
  input  logic [QW-1:0] r1_read_query,
  output logic [QW-1:0] r1_read_result,
  output logic          r1_read_rdy,
  output logic [1:0]    t_read_type,
  output logic [QW-1:0] t_read_query,
  input  logic [QW-1:0] t_read_result,
  input  logic          t_read_rdy,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e        state_q;
  logic          rr_q;
  logic [1:0]    grant_q;
  logic [1:0]    t_type_q;
  logic [QW-1:0] t_query_q;
  logic [1:0]    g_type_q;
  logic [QW-1:0] g_query_q;

  logic [1:0]    pend;
  logic [1:0]    pick;
  logic [1:0]    pick_type;
  logic [QW-1:0] pick_query;
  logic          r0_match;
  logic          r1_match;
  logic          own_match;

  assign pend[0] = (r0_read_type != READ_TYPE_NONE);
  assign pend[1] = (r1_read_type != READ_TYPE_NONE);

  ans_rr_pick2 u_pick (
    .req_i (pend),
    .ptr_i (rr_q),
    .gnt_o (pick)
  );

  assign pick_type  = pick[1] ? r1_read_type  : r0_read_type;
  assign pick_query = pick[1] ? r1_read_query : r0_read_query;

  assign r0_match  = (r0_read_type == g_type_q) && (r0_read_query == g_query_q);
  assign r1_match  = (r1_read_type == g_type_q) && (r1_read_query == g_query_q);
  assign own_match = grant_q[1] ? r1_match : r0_match;

  // Any change by the owner (NONE or a new type/query) ends the grant, even mid-lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_q      <= 1'b0;
      grant_q   <= 2'b00;
      t_type_q  <= READ_TYPE_NONE;
      t_query_q <= '0;
      g_type_q  <= READ_TYPE_NONE;
      g_query_q <= '0;
    end else if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (|pend) begin
            state_q   <= ST_GRANT;
            grant_q   <= pick;
            g_type_q  <= pick_type;
            g_query_q <= pick_query;
            t_type_q  <= pick_type;
            t_query_q <= pick_query;
          end
        end
        ST_GRANT: begin
          if (!own_match) begin
            state_q  <= ST_RELEASE;
            t_type_q <= READ_TYPE_NONE;
            rr_q     <= grant_q[0];
          end
        end
        ST_RELEASE: begin
          // Hold ownership until the table has dropped the stale answer.
          if (!t_read_rdy) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign r0_read_rdy    = (state_q == ST_GRANT) && grant_q[0] && t_read_rdy && r0_match;
  assign r1_read_rdy    = (state_q == ST_GRANT) && grant_q[1] && t_read_rdy && r1_match;
  assign r0_read_result = grant_q[0] ? t_read_result : '0;
  assign r1_read_result = grant_q[1] ? t_read_result : '0;

  assign t_read_type  = t_type_q;
  assign t_read_query = t_query_q;
  assign grant        = grant_q;

endmodule

// File: tb/tb_ans_table_arbiter.sv
// Directed bench for ans_table_arbiter: table responses are driven by hand and
// every expected value below is worked out from the arbitration rules.
module tb_ans_table_arbiter;
  import ans_table_arbiter_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic [1:0]    r0_type = 2'd0;
  logic [QW-1:0] r0_q = '0;
  logic [QW-1:0] r0_res;
  logic          r0_rdy;
  logic [1:0]    r1_type = 2'd0;
  logic [QW-1:0] r1_q = '0;
  logic [QW-1:0] r1_res;
  logic          r1_rdy;
  logic [1:0]    t_type;
  logic [QW-1:0] t_query;
  logic [QW-1:0] t_res = '0;
  logic          t_rdy = 1'b0;
  logic [1:0]    grant;

  int checks   = 0;
  int failures = 0;

  ans_table_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .ena            (ena),
    .r0_read_type   (r0_type),
    .r0_read_query  (r0_q),
    .r0_read_result (r0_res),
    .r0_read_rdy    (r0_rdy),
    .r1_read_type   (r1_type),
    .r1_read_query  (r1_q),
    .r1_read_result (r1_res),
    .r1_read_rdy    (r1_rdy),
    .t_read_type    (t_type),
    .t_read_query   (t_query),
    .t_read_result  (t_res),
    .t_read_rdy     (t_rdy),
    .grant          (grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [1:0] g, input logic [1:0] ty,
                          input logic [QW-1:0] q);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_ttype"}, 32'(t_type), 32'(ty));
    chk({tag, "_tquery"}, 32'(t_query), 32'(q));
  endtask

  initial begin
    // Reset state while rst is held
    tick();
    tick();
    chk_regs("rst", 2'b00, READ_TYPE_NONE, '0);
    chk("rst_r0rdy", 32'(r0_rdy), 0);
    chk("rst_r1rdy", 32'(r1_rdy), 0);
    rst = 1'b0;
    tick();
    chk("idle_grant", 32'(grant), 0);

    // Both request together: r0 first (rr=0), then r1
    r0_type = READ_TYPE_PMF; r0_q = 2;
    r1_type = READ_TYPE_CMF; r1_q = 15;
    #1 chk("pre_grant", 32'(grant), 0);
    tick();
    chk_regs("both_g0", 2'b01, READ_TYPE_PMF, 2);
    t_rdy = 1'b1; t_res = 7;
    #1;
    chk("both_r0rdy", 32'(r0_rdy), 1);
    chk("both_r0res", 32'(r0_res), 7);
    chk("both_r1rdy", 32'(r1_rdy), 0);
    chk("both_r1res", 32'(r1_res), 0);
    r0_type = READ_TYPE_NONE; r0_q = 0; t_rdy = 1'b0; t_res = 0;
    #1 chk("r0_drop_rdy", 32'(r0_rdy), 0);
    tick();
    chk_regs("both_rel", 2'b01, READ_TYPE_NONE, 2);
    tick();
    chk("both_idle", 32'(grant), 0);
    tick();
    chk_regs("both_g1", 2'b10, READ_TYPE_CMF, 15);

    // r1 CMF 15, table answers 40 three cycles later
    tick();
    tick();
    chk("cmf_wait_rdy", 32'(r1_rdy), 0);
    t_rdy = 1'b1; t_res = 40;
    #1;
    chk("cmf_r1rdy", 32'(r1_rdy), 1);
    chk("cmf_r1res", 32'(r1_res), 40);
    chk("cmf_r0rdy", 32'(r0_rdy), 0);
    chk("cmf_r0res", 32'(r0_res), 0);

    // r1 withdraws while table rdy is still high
    r1_type = READ_TYPE_NONE; r1_q = 0;
    #1 chk("wd_r1rdy", 32'(r1_rdy), 0);
    tick();
    chk_regs("wd_rel1", 2'b10, READ_TYPE_NONE, 15);
    tick();
    chk("wd_rel2_grant", 32'(grant), 32'(2'b10));
    t_rdy = 1'b0; t_res = 0;
    tick();
    chk("wd_idle", 32'(grant), 0);

    // r1 switches PMF 5 -> CMF 4 without going idle
    r1_type = READ_TYPE_PMF; r1_q = 5;
    tick();
    chk_regs("sw_g_pmf", 2'b10, READ_TYPE_PMF, 5);
    t_rdy = 1'b1; t_res = 9;
    #1 chk("sw_pmf_rdy", 32'(r1_rdy), 1);
    r1_type = READ_TYPE_CMF; r1_q = 4;
    #1 chk("sw_stale_rdy", 32'(r1_rdy), 0);
    tick();
    chk_regs("sw_rel", 2'b10, READ_TYPE_NONE, 5);
    chk("sw_rel_rdy", 32'(r1_rdy), 0);
    t_rdy = 1'b0; t_res = 0;
    tick();
    chk("sw_idle", 32'(grant), 0);
    tick();
    chk_regs("sw_g_cmf", 2'b10, READ_TYPE_CMF, 4);
    chk("sw_cmf_norrdy", 32'(r1_rdy), 0);
    t_rdy = 1'b1; t_res = 11;
    #1;
    chk("sw_cmf_rdy", 32'(r1_rdy), 1);
    chk("sw_cmf_res", 32'(r1_res), 11);

    // ena low for 5 cycles while the owner withdraws: everything frozen
    ena = 1'b0;
    r1_type = READ_TYPE_NONE; r1_q = 0; t_rdy = 1'b0; t_res = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_regs("ena_hold", 2'b10, READ_TYPE_CMF, 4);
    end
    ena = 1'b1;
    tick();
    chk_regs("ena_rel", 2'b10, READ_TYPE_NONE, 4);
    tick();
    chk("ena_idle", 32'(grant), 0);

    // Round robin: r0 granted, withdraws and re-requests; r1 must win next
    r0_type = READ_TYPE_ICMF; r0_q = 3;
    r1_type = READ_TYPE_PMF;  r1_q = 6;
    tick();
    chk_regs("rr_g0", 2'b01, READ_TYPE_ICMF, 3);
    r0_type = READ_TYPE_NONE; r0_q = 0;
    tick();
    chk("rr_rel", 32'(t_type), 0);
    r0_type = READ_TYPE_ICMF; r0_q = 3;
    tick();
    chk("rr_idle", 32'(grant), 0);
    tick();
    chk_regs("rr_g1", 2'b10, READ_TYPE_PMF, 6);

    // Reset pulse mid-grant: outputs clear at once, rr back to 0
    t_rdy = 1'b1; t_res = 21;
    #1 chk("pre_rst_r1rdy", 32'(r1_rdy), 1);
    rst = 1'b1;
    #1;
    chk_regs("mid_rst", 2'b00, READ_TYPE_NONE, '0);
    chk("mid_rst_r1rdy", 32'(r1_rdy), 0);
    chk("mid_rst_r1res", 32'(r1_res), 0);
    chk("mid_rst_r0res", 32'(r0_res), 0);
    tick();
    rst = 1'b0; t_rdy = 1'b0; t_res = 0;
    tick();
    chk_regs("post_rst_g", 2'b01, READ_TYPE_ICMF, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
